osc_cmd_dispatch: RTL and testbench
===================================

// Module: osc_cmd_dispatch
// PURPOSE
// Parametrised command decoder/dispatcher for the capture front end; successor to the fixed 3-channel config block.
// Takes 24-bit UART commands and drives SPI transactions (AFE gain, trigger DAC, cal EEPROM).
// Holds the config registers (trig_cfg, trig_pos, decimator, per-channel gain) and returns a 1-byte UART response.
// Adds: NUM_CH channels, one-hot slave select, SPI timeout with NAK, and a dump handshake that completes on dump_done.
// PARAMETERS
// NUM_CH    3     analog channels, 1..4; dump/gain channel field is cmd[9:8]
// TPOS_W    9     trig_pos width, <=16; value is cmd[TPOS_W-1:0]
// DEC_W     4     decimator width, <=8
// SPI_TO    1023  max cycles from wrt_SPI to SPI_done before NAK
// PORTS
// clk              in   1            system clock
// rst_n            in   1            async active-low reset
// cmd              in   24           {opcode, byte2, byte3} from UART wrapper
// cmd_rdy          in   1            cmd valid, held until clr_cmd_rdy
// clr_cmd_rdy      out  1            1-cycle pulse: command consumed
// resp_data        out  8            response byte, valid while send_resp
// send_resp        out  1            1-cycle pulse: start UART transmit
// resp_sent        in   1            UART transmit complete
// SPI_data         out  16           SPI word, stable from wrt_SPI until SPI_done/timeout
// wrt_SPI          out  1            1-cycle pulse: start SPI transaction
// ss               out  NUM_CH+2     one-hot: [0] trig DAC, [NUM_CH:1] AFE ch, [NUM_CH+1] EEPROM
// SPI_done         in   1            SPI transaction complete; EEP_data valid this cycle
// EEP_data         in   8            read data returned by EEPROM
// set_capture_done in   1            capture engine sets trig_cfg[5]
// trig_cfg         out  8            {2'b00,d,e,tt,cc}
// trig_pos         out  TPOS_W       samples captured after trigger
// decimator        out  DEC_W        log2 of sample decimation
// afe_gain         out  3*NUM_CH     packed gain codes, ch0 at [2:0]
// dump             out  1            level: dump in progress
// dump_ch          out  2            channel being dumped
// dump_done        in   1            dump engine finished
// BEHAVIOUR
// Reset: every output 0; trig_pos=0, decimator=0, afe_gain=0, trig_cfg=8'h00, FSM in IDLE.
// Opcodes: 01 DUMP, 02 CFG_GAIN, 03 TRIG_LVL, 04 TRIG_POS, 05 SET_DEC, 06 TRIG_CFG, 07 TRIG_RD, 08 EEP_WRT, 09 EEP_RD.
// Responses: ACK=8'hA5, NAK=8'hEE; EEP_RD answers with EEP_data.
// FSM: IDLE -> DECODE (cmd_rdy; latch cmd into cmd_q) -> {SPI_WAIT | DUMP_WAIT | RESP} -> RESP_WAIT -> IDLE.
// DECODE (1 cycle): register writes (04/05/06) take effect at end of DECODE; send_resp(ACK) is asserted the next cycle.
// SPI opcodes: wrt_SPI pulses in DECODE; ss is asserted from that same cycle until SPI_WAIT exits.
// CFG_GAIN: SPI_data={8'h13, LUT(g)} with g=cmd[12:10]; LUT 02,05,09,14,28,46,6B,DD; ss[ch+1]; afe_gain[ch] updated on SPI_done.
// TRIG_LVL: valid range 46..201 -> SPI_data={8'h13,cmd[7:0]}, ss[0]; out of range -> NAK, no SPI.
// EEP_WRT: SPI_data={2'b01,cmd[13:0]}; EEP_RD: SPI_data={2'b00,cmd[13:8],8'h00}; both use ss[NUM_CH+1].
// SPI_WAIT: SPI_done -> send_resp (ACK or EEP_data) next cycle; SPI_TO cycles without SPI_done -> ss=0 and NAK.
// DUMP: ch<NUM_CH -> dump=1, dump_ch=ch, wait dump_done, then ACK; ch>=NUM_CH -> NAK.
// TRIG_CFG write: trig_cfg <= {2'b00,cmd[13:8]}; writing d=0 clears capture_done.
// set_capture_done sets bit5 in any state and wins over a same-cycle TRIG_CFG write to bit5.
// TRIG_RD returns trig_cfg as it is at DECODE.
// Unknown opcode or CFG_GAIN ch>=NUM_CH -> NAK; no register change.
// RESP_WAIT: on resp_sent, pulse clr_cmd_rdy and return to IDLE. cmd_rdy is ignored outside IDLE.
// All outputs are registered; no combinational path from any input to any output.
// STRUCTURE
// osc_cmd_pkg: opcode localparams, ACK/NAK, state_t enum {IDLE,DECODE,SPI_WAIT,DUMP_WAIT,RESP,RESP_WAIT}, gain LUT function.
// Sub-module: afe_gain_lut (3-bit code -> 8-bit DAC value); everything else is inline.
// Timeout counter width is $clog2(SPI_TO+1); it clears on wrt_SPI.
// TESTING
// cmd=24'h02_0A_00 (ch2, g=2), SPI_done after 40 clks -> ss[3], SPI_data=16'h1309, afe_gain[8:6]=2, resp 8'hA5.
// cmd=24'h03_00_2D (45) -> no wrt_SPI, resp 8'hEE; cmd=24'h03_00_C9 (201) -> SPI_data=16'h13C9, ss[0], resp 8'hA5.
// cmd=24'h09_05_00, SPI_done with EEP_data=8'h3C -> SPI_data=16'h0500, ss[NUM_CH+1], resp 8'h3C.
// cmd=24'h08_05_77 with SPI_done never asserted -> ss drops after SPI_TO clks, resp 8'hEE, FSM returns to IDLE.
// TRIG_CFG 24'h06_13_00, then set_capture_done in the same cycle as a write of 24'h06_00_00 -> TRIG_RD returns 8'h20.
// cmd=24'h01_03_00 with NUM_CH=3 -> resp 8'hEE; 24'h01_01_00 -> dump=1, dump_ch=1 until dump_done, resp A5; rst_n low mid-SPI -> all outputs 0.

Source files
------------

// File: rtl/osc_cmd_dispatch_pkg.sv
// Shared definitions for the capture front-end command dispatcher:
// opcodes, response codes, FSM states and the AFE gain lookup.
package osc_cmd_dispatch_pkg;

   localparam logic [7:0] OP_DUMP     = 8'h01;
   localparam logic [7:0] OP_CFG_GAIN = 8'h02;
   localparam logic [7:0] OP_TRIG_LVL = 8'h03;
   localparam logic [7:0] OP_TRIG_POS = 8'h04;
   localparam logic [7:0] OP_SET_DEC  = 8'h05;
   localparam logic [7:0] OP_TRIG_CFG = 8'h06;
   localparam logic [7:0] OP_TRIG_RD  = 8'h07;
   localparam logic [7:0] OP_EEP_WRT  = 8'h08;
   localparam logic [7:0] OP_EEP_RD   = 8'h09;

   localparam logic [7:0] RESP_ACK = 8'hA5;
   localparam logic [7:0] RESP_NAK = 8'hEE;

   // Trigger DAC only accepts levels inside this window
   localparam logic [7:0] TRIG_LVL_MIN = 8'd46;
   localparam logic [7:0] TRIG_LVL_MAX = 8'd201;

   // Command byte shared by the AFE gain DAC and the trigger DAC
   localparam logic [7:0] DAC_SPI_CMD = 8'h13;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      SPI_WAIT,
      DUMP_WAIT,
      RESP,
      RESP_WAIT
   } state_t;

   // Gain code to DAC setting (roughly logarithmic steps)
   function automatic logic [7:0] gain_lut(input logic [2:0] code);
      logic [7:0] val;
      case (code)
         3'd0:    val = 8'h02;
         3'd1:    val = 8'h05;
         3'd2:    val = 8'h09;
         3'd3:    val = 8'h14;
         3'd4:    val = 8'h28;
         3'd5:    val = 8'h46;
         3'd6:    val = 8'h6B;
         default: val = 8'hDD;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/osc_cmd_dispatch_if.sv
// UART command/response and SPI bus bundle between the dispatcher
// (master) and the UART wrapper / SPI engine side (slave).
interface osc_cmd_dispatch_if #(
   parameter int NUM_CH = 3
) ();
   logic [23:0]       cmd;
   logic              cmd_rdy;
   logic              clr_cmd_rdy;
   logic [7:0]        resp_data;
   logic              send_resp;
   logic              resp_sent;
   logic [15:0]       SPI_data;
   logic              wrt_SPI;
   logic [NUM_CH+1:0] ss;
   logic              SPI_done;
   logic [7:0]        EEP_data;

   modport master (
      input  cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
      output clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
   );

   modport slave (
      output cmd, cmd_rdy, resp_sent, SPI_done, EEP_data,
      input  clr_cmd_rdy, resp_data, send_resp, SPI_data, wrt_SPI, ss
   );
endinterface

// File: rtl/osc_cmd_dispatch_afe_gain_lut.sv
// Maps a 3-bit AFE gain code to the 8-bit DAC value sent over SPI.
module afe_gain_lut
   import osc_cmd_dispatch_pkg::*;
(
   input  logic [2:0] i_code,
   output logic [7:0] o_dac
);
   assign o_dac = gain_lut(i_code);
endmodule

// File: rtl/osc_cmd_dispatch.sv
// Command decoder/dispatcher: accepts 24-bit UART commands, runs the
// SPI transactions they need, holds the capture config registers and
// answers each command with a single response byte.
module osc_cmd_dispatch
   import osc_cmd_dispatch_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int TPOS_W = 9,
   parameter int DEC_W  = 4,
   parameter int SPI_TO = 1023
) (
   input  logic                clk,
   input  logic                rst_n,
   osc_cmd_dispatch_if.master  bus,
   input  logic                set_capture_done,
   output logic [7:0]          trig_cfg,
   output logic [TPOS_W-1:0]   trig_pos,
   output logic [DEC_W-1:0]    decimator,
   output logic [3*NUM_CH-1:0] afe_gain,
   output logic                dump,
   output logic [1:0]          dump_ch,
   input  logic                dump_done
);

   localparam int SS_W  = NUM_CH + 2;
   localparam int CNT_W = $clog2(SPI_TO + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPI_TO);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [7:0]          r_op;
   logic [13:0]         r_arg;
   logic [TPOS_W-1:0]   r_pos;
   logic [CNT_W-1:0]    r_cnt;

   logic                r_clr_cmd_rdy;
   logic [7:0]          r_resp_data;
   logic                r_send_resp;
   logic [15:0]         r_SPI_data;
   logic                r_wrt_SPI;
   logic [SS_W-1:0]     r_ss;
   logic [7:0]          r_trig_cfg;
   logic [TPOS_W-1:0]   r_trig_pos;
   logic [DEC_W-1:0]    r_decimator;
   logic [3*NUM_CH-1:0] r_afe_gain;
   logic                r_dump;
   logic [1:0]          r_dump_ch;

   logic [7:0]          w_op_in;
   logic [1:0]          w_ch_in;
   logic [1:0]          w_ch_q;
   logic                w_ch_in_ok;
   logic                w_ch_q_ok;
   logic                w_accept;
   logic                w_timeout;
   logic [7:0]          w_lut;
   logic                w_spi_go;
   logic [15:0]         w_spi_data;
   logic [SS_W-1:0]     w_ss;
   logic [7:0]          w_dec_resp;

   assign w_op_in    = bus.cmd[23:16];
   assign w_ch_in    = bus.cmd[9:8];
   assign w_ch_q     = r_arg[9:8];
   assign w_ch_in_ok = (int'(w_ch_in) < NUM_CH);
   assign w_ch_q_ok  = (int'(w_ch_q) < NUM_CH);
   // r_clr_cmd_rdy guards against re-accepting a command whose cmd_rdy has not dropped yet
   assign w_accept   = (r_state == IDLE) && bus.cmd_rdy && !r_clr_cmd_rdy;
   assign w_timeout  = (r_state == SPI_WAIT) && !bus.SPI_done && (r_cnt == CNT_MAX);

   afe_gain_lut u_gain_lut (
      .i_code (bus.cmd[12:10]),
      .o_dac  (w_lut)
   );

   // SPI decode of the incoming command so wrt_SPI/ss are registered into DECODE
   always_comb begin
      w_spi_go   = 1'b0;
      w_spi_data = '0;
      w_ss       = '0;
      case (w_op_in)
         OP_CFG_GAIN: begin
            if (w_ch_in_ok) begin
               w_spi_go   = 1'b1;
               w_spi_data = {DAC_SPI_CMD, w_lut};
               w_ss[int'(w_ch_in) + 1] = 1'b1;
            end
         end
         OP_TRIG_LVL: begin
            if ((bus.cmd[7:0] >= TRIG_LVL_MIN) && (bus.cmd[7:0] <= TRIG_LVL_MAX)) begin
               w_spi_go   = 1'b1;
               w_spi_data = {DAC_SPI_CMD, bus.cmd[7:0]};
               w_ss[0]    = 1'b1;
            end
         end
         OP_EEP_WRT: begin
            w_spi_go       = 1'b1;
            w_spi_data     = {2'b01, bus.cmd[13:0]};
            w_ss[SS_W-1]   = 1'b1;
         end
         OP_EEP_RD: begin
            w_spi_go       = 1'b1;
            w_spi_data     = {2'b00, bus.cmd[13:8], 8'h00};
            w_ss[SS_W-1]   = 1'b1;
         end
         default: ;
      endcase
   end

   // Immediate response for commands answered straight out of DECODE
   always_comb begin
      w_dec_resp = RESP_NAK;
      case (r_op)
         OP_TRIG_POS, OP_SET_DEC, OP_TRIG_CFG: w_dec_resp = RESP_ACK;
         OP_TRIG_RD:                           w_dec_resp = r_trig_cfg;
         default: ;
      endcase
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:      if (w_accept) w_state_nxt = DECODE;
         DECODE: begin
            if (r_wrt_SPI)                           w_state_nxt = SPI_WAIT;
            else if ((r_op == OP_DUMP) && w_ch_q_ok) w_state_nxt = DUMP_WAIT;
            else                                     w_state_nxt = RESP;
         end
         SPI_WAIT:  if (bus.SPI_done || w_timeout) w_state_nxt = RESP;
         DUMP_WAIT: if (dump_done) w_state_nxt = RESP;
         RESP:      w_state_nxt = RESP_WAIT;
         RESP_WAIT: if (bus.resp_sent) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // SPI timeout counter: cycles elapsed since wrt_SPI
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   r_cnt <= '0;
      else if (r_wrt_SPI)           r_cnt <= CNT_W'(1);
      else if (r_state == SPI_WAIT) r_cnt <= r_cnt + CNT_W'(1);
   end

   // Command latch, registered outputs and config registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op          <= '0;
         r_arg         <= '0;
         r_pos         <= '0;
         r_clr_cmd_rdy <= 1'b0;
         r_resp_data   <= '0;
         r_send_resp   <= 1'b0;
         r_SPI_data    <= '0;
         r_wrt_SPI     <= 1'b0;
         r_ss          <= '0;
         r_trig_cfg    <= '0;
         r_trig_pos    <= '0;
         r_decimator   <= '0;
         r_afe_gain    <= '0;
         r_dump        <= 1'b0;
         r_dump_ch     <= '0;
      end else begin
         r_clr_cmd_rdy <= 1'b0;
         r_send_resp   <= 1'b0;
         r_wrt_SPI     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op  <= w_op_in;
                  r_arg <= bus.cmd[13:0];
                  r_pos <= bus.cmd[TPOS_W-1:0];
                  if (w_spi_go) begin
                     r_wrt_SPI  <= 1'b1;
                     r_SPI_data <= w_spi_data;
                     r_ss       <= w_ss;
                  end
               end
            end
            DECODE: begin
               case (r_op)
                  OP_TRIG_POS: r_trig_pos  <= r_pos;
                  OP_SET_DEC:  r_decimator <= r_arg[DEC_W-1:0];
                  OP_TRIG_CFG: r_trig_cfg  <= {2'b00, r_arg[13:8]};
                  OP_DUMP: begin
                     if (w_ch_q_ok) begin
                        r_dump    <= 1'b1;
                        r_dump_ch <= w_ch_q;
                     end
                  end
                  default: ;
               endcase
               if (w_state_nxt == RESP) begin
                  r_send_resp <= 1'b1;
                  r_resp_data <= w_dec_resp;
               end
            end
            SPI_WAIT: begin
               if (bus.SPI_done) begin
                  r_ss        <= '0;
                  r_send_resp <= 1'b1;
                  r_resp_data <= (r_op == OP_EEP_RD) ? bus.EEP_data : RESP_ACK;
                  if (r_op == OP_CFG_GAIN)
                     r_afe_gain[3*int'(w_ch_q) +: 3] <= r_arg[12:10];
               end else if (w_timeout) begin
                  r_ss        <= '0;
                  r_send_resp <= 1'b1;
                  r_resp_data <= RESP_NAK;
               end
            end
            DUMP_WAIT: begin
               if (dump_done) begin
                  r_dump      <= 1'b0;
                  r_send_resp <= 1'b1;
                  r_resp_data <= RESP_ACK;
               end
            end
            RESP_WAIT: begin
               if (bus.resp_sent) r_clr_cmd_rdy <= 1'b1;
            end
            default: ;
         endcase
         // Capture engine flag wins over a same-cycle TRIG_CFG write
         if (set_capture_done) r_trig_cfg[5] <= 1'b1;
      end
   end

   assign bus.clr_cmd_rdy = r_clr_cmd_rdy;
   assign bus.resp_data   = r_resp_data;
   assign bus.send_resp   = r_send_resp;
   assign bus.SPI_data    = r_SPI_data;
   assign bus.wrt_SPI     = r_wrt_SPI;
   assign bus.ss          = r_ss;
   assign trig_cfg        = r_trig_cfg;
   assign trig_pos        = r_trig_pos;
   assign decimator       = r_decimator;
   assign afe_gain        = r_afe_gain;
   assign dump            = r_dump;
   assign dump_ch         = r_dump_ch;

endmodule

// File: tb/tb_osc_cmd_dispatch.sv
// Testbench for osc_cmd_dispatch: directed scenarios followed by random
// commands, each compared against a behavioural model of the command set.
module tb_osc_cmd_dispatch;

   localparam int NUM_CH = 3;
   localparam int TPOS_W = 9;
   localparam int DEC_W  = 4;
   localparam int SPI_TO = 1023;
   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'hEE;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_capture_done = 1'b0;
   logic dump_done = 1'b0;
   logic [7:0]          trig_cfg;
   logic [TPOS_W-1:0]   trig_pos;
   logic [DEC_W-1:0]    decimator;
   logic [3*NUM_CH-1:0] afe_gain;
   logic                dump;
   logic [1:0]          dump_ch;

   osc_cmd_dispatch_if #(.NUM_CH(NUM_CH)) bus ();

   osc_cmd_dispatch #(.NUM_CH(NUM_CH), .TPOS_W(TPOS_W), .DEC_W(DEC_W), .SPI_TO(SPI_TO)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .bus              (bus),
      .set_capture_done (set_capture_done),
      .trig_cfg         (trig_cfg),
      .trig_pos         (trig_pos),
      .decimator        (decimator),
      .afe_gain         (afe_gain),
      .dump             (dump),
      .dump_ch          (dump_ch),
      .dump_done        (dump_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state
   logic [7:0] lut [8] = '{8'h02, 8'h05, 8'h09, 8'h14, 8'h28, 8'h46, 8'h6B, 8'hDD};
   int m_tcfg, m_tpos, m_dec;
   int m_gain [NUM_CH];
   int e_resp, e_spi, e_data, e_ss, e_dump, e_dch;

   // Observations
   int o_resp, o_saw_spi, o_spi_data, o_ss, o_ss_ok, o_spi_cyc, o_resp_cyc;
   int o_ss_at_resp, o_saw_dump, o_dump_ch, o_dump_ok, o_dump_at_resp, o_nsend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int gain_packed();
      int s = 0;
      for (int i = 0; i < NUM_CH; i++) s += m_gain[i] << (3 * i);
      return s;
   endfunction

   task automatic model_reset();
      m_tcfg = 0; m_tpos = 0; m_dec = 0;
      for (int i = 0; i < NUM_CH; i++) m_gain[i] = 0;
   endtask

   // Expected behaviour of one command, straight from the command-set rules
   task automatic model_cmd(input logic [23:0] c, input bit tmo, input logic [7:0] eep, input bit scd);
      int op, b2, b3, ch, g;
      op = int'(c[23:16]); b2 = int'(c[15:8]); b3 = int'(c[7:0]);
      ch = b2 % 4; g = (b2 / 4) % 8;
      e_resp = NAK; e_spi = 0; e_data = 0; e_ss = 0; e_dump = 0; e_dch = 0;
      case (op)
         1: if (ch < NUM_CH) begin e_dump = 1; e_dch = ch; e_resp = ACK; end
         2: if (ch < NUM_CH) begin
               e_spi = 1; e_data = 32'h1300 + int'(lut[g]); e_ss = 1 << (ch + 1);
               if (!tmo) begin e_resp = ACK; m_gain[ch] = g; end
            end
         3: if (b3 >= 46 && b3 <= 201) begin
               e_spi = 1; e_data = 32'h1300 + b3; e_ss = 1;
               if (!tmo) e_resp = ACK;
            end
         4: begin m_tpos = int'(c[15:0]) % (1 << TPOS_W); e_resp = ACK; end
         5: begin m_dec = b3 % (1 << DEC_W); e_resp = ACK; end
         6: begin m_tcfg = b2 % 64; e_resp = ACK; end
         7: e_resp = m_tcfg;
         8: begin
               e_spi = 1; e_data = 32'h4000 + (int'(c[15:0]) % 16384); e_ss = 1 << (NUM_CH + 1);
               if (!tmo) e_resp = ACK;
            end
         9: begin
               e_spi = 1; e_data = (b2 % 64) * 256; e_ss = 1 << (NUM_CH + 1);
               if (!tmo) e_resp = int'(eep);
            end
         default: ;
      endcase
      if (scd) m_tcfg = m_tcfg | 32;
   endtask

   // Plays UART wrapper, SPI engine and dump engine for one command
   task automatic run_cmd(input logic [23:0] c, input int spi_dly, input logic [7:0] eep,
                          input int dump_dly, input bit scd);
      int spi_at, dump_at;
      bit done;
      o_resp = -1; o_saw_spi = 0; o_spi_data = 0; o_ss = 0; o_ss_ok = 1; o_spi_cyc = -1;
      o_resp_cyc = -1; o_ss_at_resp = -1; o_saw_dump = 0; o_dump_ch = 0; o_dump_ok = 1;
      o_dump_at_resp = -1; o_nsend = 0;
      spi_at = -1; dump_at = -1; done = 0;
      @(negedge clk);
      bus.cmd = c;
      bus.cmd_rdy = 1'b1;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         bus.SPI_done = 1'b0; bus.resp_sent = 1'b0; dump_done = 1'b0;
         set_capture_done = scd && (i == 0);
         if (bus.wrt_SPI) begin
            o_saw_spi = 1; o_spi_cyc = i; o_spi_data = int'(bus.SPI_data); o_ss = int'(bus.ss);
            spi_at = i;
         end else if (spi_at >= 0 && o_resp_cyc < 0 && !bus.send_resp && int'(bus.ss) != o_ss)
            o_ss_ok = 0;
         if (spi_at >= 0 && spi_dly > 0 && i == spi_at + spi_dly) begin
            bus.SPI_done = 1'b1; bus.EEP_data = eep;
         end
         if (dump && dump_at < 0) begin o_saw_dump = 1; o_dump_ch = int'(dump_ch); dump_at = i; end
         if (dump_at >= 0 && i <= dump_at + dump_dly && !dump) o_dump_ok = 0;
         if (dump_at >= 0 && i == dump_at + dump_dly) dump_done = 1'b1;
         if (bus.send_resp) begin
            o_nsend++;
            if (o_resp_cyc < 0) begin
               o_resp_cyc = i; o_resp = int'(bus.resp_data);
               o_ss_at_resp = int'(bus.ss); o_dump_at_resp = int'(dump);
            end
         end
         if (o_resp_cyc >= 0 && i == o_resp_cyc + 2) bus.resp_sent = 1'b1;
         if (bus.clr_cmd_rdy) begin bus.cmd_rdy = 1'b0; done = 1; end
      end
      bus.cmd_rdy = 1'b0; bus.SPI_done = 1'b0; bus.resp_sent = 1'b0;
      dump_done = 1'b0; set_capture_done = 1'b0;
      if (!done) chk("handshake_bound", 0, 1);
   endtask

   task automatic exec(input string tag, input logic [23:0] c, input int spi_dly,
                       input logic [7:0] eep, input int dump_dly, input bit scd);
      model_cmd(c, spi_dly == 0, eep, scd);
      run_cmd(c, spi_dly, eep, dump_dly, scd);
      chk({tag, "_resp"}, o_resp, e_resp);
      chk({tag, "_wrt_spi"}, o_saw_spi, e_spi);
      if (e_spi != 0) begin
         chk({tag, "_spi_data"}, o_spi_data, e_data);
         chk({tag, "_ss"}, o_ss, e_ss);
         chk({tag, "_ss_held"}, o_ss_ok, 1);
         chk({tag, "_spi_cyc"}, o_spi_cyc, 0);
         chk({tag, "_ss_released"}, o_ss_at_resp, 0);
      end
      chk({tag, "_dump"}, o_saw_dump, e_dump);
      if (e_dump != 0) begin
         chk({tag, "_dump_ch"}, o_dump_ch, e_dch);
         chk({tag, "_dump_held"}, o_dump_ok, 1);
         chk({tag, "_dump_end"}, o_dump_at_resp, 0);
      end
      chk({tag, "_nsend"}, o_nsend, 1);
      chk({tag, "_trig_cfg"}, 32'(trig_cfg), m_tcfg);
      chk({tag, "_trig_pos"}, 32'(trig_pos), m_tpos);
      chk({tag, "_decimator"}, 32'(decimator), m_dec);
      chk({tag, "_afe_gain"}, 32'(afe_gain), gain_packed());
   endtask

   initial begin
      logic [23:0] c;
      int op, sel;
      bit seen;
      bus.cmd = '0; bus.cmd_rdy = 1'b0; bus.resp_sent = 1'b0;
      bus.SPI_done = 1'b0; bus.EEP_data = '0;
      model_reset();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_ctrl", {28'd0, bus.clr_cmd_rdy, bus.send_resp, bus.wrt_SPI, dump}, 0);
      chk("rst_resp_data", 32'(bus.resp_data), 0);
      chk("rst_spi_data", 32'(bus.SPI_data), 0);
      chk("rst_ss", 32'(bus.ss), 0);
      chk("rst_regs", {trig_cfg, 7'd0, trig_pos, decimator, 4'd0}, 0);
      chk("rst_gain", {21'd0, afe_gain, dump_ch}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed scenarios
      exec("gain_ch2", 24'h020A00, 40, 8'h00, 1, 1'b0);
      exec("lvl_45", 24'h03002D, 5, 8'h00, 1, 1'b0);
      exec("lvl_46", 24'h03002E, 3, 8'h00, 1, 1'b0);
      exec("lvl_201", 24'h0300C9, 7, 8'h00, 1, 1'b0);
      exec("lvl_202", 24'h0300CA, 7, 8'h00, 1, 1'b0);
      exec("eep_rd", 24'h090500, 12, 8'h3C, 1, 1'b0);
      exec("eep_wrt_to", 24'h080577, 0, 8'h00, 1, 1'b0);
      chk("to_latency", (o_resp_cyc >= SPI_TO && o_resp_cyc <= SPI_TO + 2), 1);
      exec("tcfg_13", 24'h061300, 1, 8'h00, 1, 1'b0);
      exec("tcfg_scd", 24'h060000, 1, 8'h00, 1, 1'b1);
      exec("trig_rd", 24'h070000, 1, 8'h00, 1, 1'b0);
      exec("dump_ch3", 24'h010300, 1, 8'h00, 4, 1'b0);
      exec("dump_ch1", 24'h010100, 1, 8'h00, 6, 1'b0);
      exec("gain_ch3", 24'h021F00, 5, 8'h00, 1, 1'b0);
      exec("op_00", 24'h001234, 1, 8'h00, 1, 1'b0);
      exec("op_0a", 24'h0A1234, 1, 8'h00, 1, 1'b0);
      exec("tpos", 24'h0401FF, 1, 8'h00, 1, 1'b0);
      chk("tpos_latency", o_resp_cyc, 1);
      exec("dec", 24'h05000B, 1, 8'h00, 1, 1'b0);

      // Random commands against the model
      for (int k = 0; k < 40; k++) begin
         op  = $urandom_range(0, 10);
         c   = {op[7:0], 8'($urandom), 8'($urandom)};
         sel = $urandom_range(0, 5);
         if (op == 3 && sel < 4) begin
            case (sel)
               0: c[7:0] = 8'd45;
               1: c[7:0] = 8'd46;
               2: c[7:0] = 8'd201;
               default: c[7:0] = 8'd202;
            endcase
         end
         exec("rnd", c, $urandom_range(1, 15), 8'($urandom), $urandom_range(1, 10), 1'b0);
      end

      // Reset in the middle of an SPI transaction
      @(negedge clk);
      bus.cmd = 24'h080577;
      bus.cmd_rdy = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (bus.wrt_SPI) seen = 1;
      end
      chk("mid_spi_start", seen, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ctrl", {28'd0, bus.clr_cmd_rdy, bus.send_resp, bus.wrt_SPI, dump}, 0);
      chk("mid_rst_ss", 32'(bus.ss), 0);
      chk("mid_rst_spi_data", 32'(bus.SPI_data), 0);
      chk("mid_rst_regs", {trig_cfg, 7'd0, trig_pos, decimator, 4'd0}, 0);
      chk("mid_rst_gain", {21'd0, afe_gain, dump_ch}, 0);
      @(negedge clk);
      bus.cmd_rdy = 1'b0;
      rst_n = 1'b1;
      model_reset();
      exec("post_rst_rd", 24'h070000, 1, 8'h00, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
